// File: rtl/imem_line_responder.sv
// imem_line_responder: single-outstanding instruction fetch responder backed
// by a one-line (32 B) fill buffer that is refilled from a 4x64-bit burst memory.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   imem_addr/rmask/inv   - fetch request (any nonzero rmask), line invalidate
//   imem_rdata/resp       - registered response word and one-cycle strobe
//   bmem_addr/read        - burst request, held until bmem_ready
//   bmem_ready            - burst request accepted
//   bmem_raddr/rdata/rvalid - returning burst beats, in order 0..3
module imem_line_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic        imem_inv,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int unsigned TAG_W  = 27;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned NBEATS = 4;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  state_e                       state_q, state_d;
  logic [NBEATS-1:0][BEAT_W-1:0] line_q, line_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic                         valid_q, valid_d;
  logic [1:0]                   beat_cnt_q, beat_cnt_d;
  logic [31:2]                  addr_q, addr_d;
  logic                         inv_pend_q, inv_pend_d;
  logic                         resp_q, resp_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         read_q, read_d;
  logic [31:0]                  baddr_q, baddr_d;

  logic                         req_c;
  logic                         hit_c;
  logic [BEAT_W-1:0]            fill_beat_c;

  // Word offset bits and the returning line address carry no extra information.
  logic                         unused_ok;
  assign unused_ok = ^{imem_addr[1:0], bmem_raddr};

  assign req_c = |imem_rmask;
  assign hit_c = valid_q && (imem_addr[31:5] == tag_q) && !imem_inv;
  // Beat 3 is still on the bus when the response word is chosen.
  assign fill_beat_c = (addr_q[4:3] == 2'd3) ? bmem_rdata : line_q[addr_q[4:3]];

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    inv_pend_d = inv_pend_q;
    resp_d     = 1'b0;
    rdata_d    = rdata_q;
    read_d     = read_q;
    baddr_d    = baddr_q;

    if (imem_inv) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          if (hit_c) begin
            resp_d  = 1'b1;
            rdata_d = imem_addr[2] ? line_q[imem_addr[4:3]][63:32]
                                   : line_q[imem_addr[4:3]][31:0];
          end else begin
            // Line contents are about to be overwritten beat by beat.
            valid_d    = 1'b0;
            addr_d     = imem_addr[31:2];
            baddr_d    = {imem_addr[31:5], 5'b0};
            read_d     = 1'b1;
            inv_pend_d = 1'b0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (imem_inv) inv_pend_d = 1'b1;
        if (bmem_ready) begin
          read_d     = 1'b0;
          beat_cnt_d = 2'd0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (imem_inv) inv_pend_d = 1'b1;
        if (bmem_rvalid) begin
          line_d[beat_cnt_q] = bmem_rdata;
          beat_cnt_d         = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            tag_d   = addr_q[31:5];
            // An invalidate seen at any point of the fill leaves the line invalid.
            valid_d = !(inv_pend_q || imem_inv);
            resp_d  = 1'b1;
            rdata_d = addr_q[2] ? fill_beat_c[63:32] : fill_beat_c[31:0];
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      beat_cnt_q <= 2'd0;
      addr_q     <= '0;
      inv_pend_q <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
      read_q     <= 1'b0;
      baddr_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      inv_pend_q <= inv_pend_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      read_q     <= read_d;
      baddr_q    <= baddr_d;
    end
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign bmem_read  = read_q;
  assign bmem_addr  = baddr_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Scoreboarded bench for imem_line_responder: directed requests push expected
// (word, cycle) pairs; a negedge monitor pops and compares on every imem_resp.
module tb_imem_line_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        imem_inv;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  imem_line_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .imem_inv   (imem_inv),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (rst_n && imem_resp) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp with data %h expected no resp (cycle %0d)", imem_rdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", imem_rdata, mon_e.data);
        check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  function automatic logic [31:0] word(input logic [31:0] salt, input int w);
    return (32'(w) * 32'h1111_1111) ^ salt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [31:0] data, input int lat);
    exp_q.push_back('{data: data, cyc: cyc + lat});
  endtask

  task automatic request(input logic [31:0] addr, input logic inv);
    imem_addr  = addr;
    imem_rmask = 4'hF;
    imem_inv   = inv;
    tick();
    imem_rmask = 4'h0;
    imem_inv   = 1'b0;
  endtask

  // Plays the backing memory for one miss that has just been requested.
  task automatic fill(input logic [31:0] line, input logic [31:0] salt, input int rdy_wait,
                      input int gap, input logic spurious, input logic inv);
    check("miss_bmem_read", {31'd0, bmem_read}, 32'd1);
    check("miss_bmem_addr", bmem_addr, line);
    for (int r = 0; r < rdy_wait; r++) begin
      bmem_ready = 1'b0;
      tick();
      check("stall_bmem_read", {31'd0, bmem_read}, 32'd1);
      check("stall_bmem_addr", bmem_addr, line);
    end
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        if (b == 1 && g == 0) begin
          if (spurious) begin
            imem_rmask = 4'hF;
            imem_addr  = line ^ 32'h0000_0100;
          end
          if (inv) imem_inv = 1'b1;
        end
        tick();
        imem_rmask = 4'h0;
        imem_inv   = 1'b0;
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = line;
      bmem_rdata  = {word(salt, 2 * b + 1), word(salt, 2 * b)};
      tick();
      bmem_rvalid = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_addr   = 32'd0;
    imem_rmask  = 4'h0;
    imem_inv    = 1'b0;
    bmem_ready  = 1'b0;
    bmem_raddr  = 32'd0;
    bmem_rdata  = 64'd0;
    bmem_rvalid = 1'b0;
    tick();
    tick();
    check("rst_resp",  {31'd0, imem_resp}, 32'd0);
    check("rst_rdata", imem_rdata, 32'd0);
    check("rst_bread", {31'd0, bmem_read}, 32'd0);
    check("rst_baddr", bmem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Cold miss, zero-wait memory.
    expect_resp(32'h1111_1111, 6);
    request(32'h1000_0004, 1'b0);
    fill(32'h1000_0000, 32'd0, 0, 0, 1'b0, 1'b0);

    // Hit streak, back-to-back with each response.
    for (int k = 0; k < 8; k++) begin
      expect_resp(word(32'd0, k), 1);
      request(32'h1000_0000 + 32'(4 * k), 1'b0);
      check("hit_bmem_read", {31'd0, bmem_read}, 32'd0);
    end
    expect_resp(32'h5555_5555, 1);
    request(32'h1000_0017, 1'b0);
    check("hit_lowbits_bread", {31'd0, bmem_read}, 32'd0);

    // Backpressure: 3 ready stalls, one gap before every beat, spurious request mid-fill.
    expect_resp(word(32'h0F0F_0000, 3), 6 + 3 + 4);
    request(32'h3000_000C, 1'b0);
    fill(32'h3000_0000, 32'h0F0F_0000, 3, 1, 1'b1, 1'b0);

    // Invalidate during fill; word 6 of the line also exercises the beat-3 bypass.
    expect_resp(word(32'hA5A5_0000, 6), 6 + 4);
    request(32'h2000_0058, 1'b0);
    fill(32'h2000_0040, 32'hA5A5_0000, 0, 1, 1'b0, 1'b1);
    expect_resp(word(32'hA5A5_0000, 4), 6);
    request(32'h2000_0050, 1'b0);
    fill(32'h2000_0040, 32'hA5A5_0000, 0, 0, 1'b0, 1'b0);

    // Line is now valid: confirm a hit, then an invalidate with a request must miss.
    expect_resp(word(32'hA5A5_0000, 2), 1);
    request(32'h2000_0048, 1'b0);
    check("valid_hit_bread", {31'd0, bmem_read}, 32'd0);
    expect_resp(word(32'hA5A5_0000, 1), 6);
    request(32'h2000_0044, 1'b1);
    fill(32'h2000_0040, 32'hA5A5_0000, 0, 0, 1'b0, 1'b0);

    // Reset after beat 1 of a fill; remaining beats arrive around and after reset.
    request(32'h4000_0000, 1'b0);
    check("rmf_bmem_read", {31'd0, bmem_read}, 32'd1);
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h4000_0000;
      bmem_rdata  = {word(32'h7777_0000, 2 * b + 1), word(32'h7777_0000, 2 * b)};
      tick();
    end
    bmem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rmf_resp",  {31'd0, imem_resp}, 32'd0);
    check("rmf_rdata", imem_rdata, 32'd0);
    check("rmf_bread", {31'd0, bmem_read}, 32'd0);
    check("rmf_baddr", bmem_addr, 32'd0);
    bmem_rvalid = 1'b1;
    bmem_rdata  = {word(32'h7777_0000, 5), word(32'h7777_0000, 4)};
    tick();
    rst_n      = 1'b1;
    bmem_rdata = {word(32'h7777_0000, 7), word(32'h7777_0000, 6)};
    tick();
    bmem_rvalid = 1'b0;
    tick();
    check("rmf_post_resp", {31'd0, imem_resp}, 32'd0);
    check("rmf_post_bread", {31'd0, bmem_read}, 32'd0);
    // The line that was valid before reset must miss now.
    expect_resp(word(32'hA5A5_0000, 2), 6);
    request(32'h2000_0048, 1'b0);
    fill(32'h2000_0040, 32'hA5A5_0000, 0, 0, 1'b0, 1'b0);

    tick();
    tick();
    tick();
    check("pending_resps", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
